rot_pixel_framer: RTL and testbench

Downstream stage of the rotation adapter. The adapter has no backpressure: once its mode goes high it emits one rotated pixel per clock. This block captures that free-running stream into a small FIFO and re-emits it as a valid/ready stream with start-of-frame, end-of-line and end-of-frame markers. It also flags overflow, short frames and row-jump misalignment. It sits between the adapter's data_out and the output writer / display path.

---
 rtl/rot_pixel_framer.sv | 165 ++++++++++++++++
 tb/tb_rot_pixel_framer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rot_pixel_framer.sv
// rot_pixel_framer: frames the free-running rotated pixel stream into a valid/ready stream with sof/eol/eof markers.
// Optional FRAMER_JUMP_CHECK_EN: checks pix_jump against row boundaries and drives jump_err; otherwise jump_err is 0.
module rot_pixel_framer #(
  parameter int IMG_W      = 1024,
  parameter int IMG_H      = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter int IN_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_in,
  input  logic [7:0] pix_in,
  input  logic       pix_jump,
  input  logic       pix_done,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_sof,
  output logic       m_eol,
  output logic       m_eof,
  output logic       frame_active,
  output logic       frame_done,
  output logic       overflow,
  output logic       short_frame,
  output logic       jump_err
);
  localparam int TOT = IMG_W * IMG_H;
  localparam int CW  = TOT > 1 ? $clog2(TOT) : 1;
  localparam int XW  = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int YW  = IMG_H > 1 ? $clog2(IMG_H) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] IN_LAST  = CW'(TOT - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
  localparam logic [2:0]    LAT_LAST = 3'(IN_LATENCY > 0 ? IN_LATENCY - 1 : 0);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT_LAT, CAPTURE, DRAIN, DONE} state_t;

  state_t        r_state, w_state_nx;
  logic          r_mode_d;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt, w_cnt_nx;
  logic [CW-1:0] r_in_cnt;
  logic [XW-1:0] r_out_col;
  logic [YW-1:0] r_out_row;
  logic [2:0]    r_lat;
  logic          r_active, r_done, r_ovf, r_short, r_jerr;
  logic          w_rise, w_fall, w_start, w_abort, w_cap, w_last, w_short;
  logic          w_try, w_push, w_pop, w_full, w_drop, w_flush, w_fin, w_col_end;

  assign w_rise    = mode_in && !r_mode_d;
  assign w_fall    = !mode_in && r_mode_d;
  assign w_start   = r_state == IDLE && w_rise;
  assign w_abort   = w_fall && (r_state == WAIT_LAT || r_state == CAPTURE || r_state == DRAIN);
  assign w_flush   = w_start || w_abort;
  assign w_cap     = r_state == CAPTURE && !w_fall;
  assign w_last    = r_in_cnt == IN_LAST;
  assign w_short   = w_cap && pix_done && !w_last;
  assign w_try     = w_cap && !w_short;
  assign w_pop     = m_valid && m_ready;
  assign w_full    = r_cnt == DEPTH;
  assign w_push    = w_try && (!w_full || w_pop);
  assign w_drop    = w_try && !w_push;
  assign w_cnt_nx  = r_cnt + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
  assign w_fin     = r_state == DRAIN && !w_fall && w_cnt_nx == '0;
  assign w_col_end = r_out_col == X_LAST;

`ifdef FRAMER_JUMP_CHECK_EN
  logic [XW-1:0] r_in_col;
  logic          w_jerr;
  // Input column tracker so row starts are recognised without a modulo.
  always_ff @(posedge clk)
    if (rst || w_start) r_in_col <= '0;
    else if (w_cap) r_in_col <= (r_in_col == X_LAST) ? '0 : r_in_col + 1'b1;
  assign w_jerr = w_cap && (pix_jump != (r_in_col == '0 && r_in_cnt != '0));
`else
  logic w_jerr, w_unused;
  assign w_jerr   = 1'b0;
  assign w_unused = pix_jump;
`endif

  // Registered copy of mode_in for edge detection.
  always_ff @(posedge clk)
    if (rst) r_mode_d <= 1'b0;
    else r_mode_d <= mode_in;

  // Frame state register.
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nx;

  // Next-state logic; a falling mode_in mid-frame aborts back to IDLE.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:     w_state_nx = !w_rise ? IDLE : (IN_LATENCY == 0) ? CAPTURE : WAIT_LAT;
      WAIT_LAT: w_state_nx = w_fall ? IDLE : (r_lat == LAT_LAST) ? CAPTURE : WAIT_LAT;
      CAPTURE:  w_state_nx = w_fall ? IDLE : (w_short || w_last) ? DRAIN : CAPTURE;
      DRAIN:    w_state_nx = w_fall ? IDLE : w_fin ? DONE : DRAIN;
      DONE:     w_state_nx = mode_in ? DONE : IDLE;
      default:  w_state_nx = IDLE;
    endcase
  end

  // FIFO pointers and occupancy; flushed on frame start and abort.
  always_ff @(posedge clk)
    if (rst || w_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_push);
      r_rp  <= r_rp + AW'(w_pop);
      r_cnt <= w_cnt_nx;
    end

  // FIFO storage write.
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= pix_in;

  // Latency, input index and output position counters.
  always_ff @(posedge clk)
    if (rst || w_start) begin
      r_lat     <= '0;
      r_in_cnt  <= '0;
      r_out_col <= '0;
      r_out_row <= '0;
    end else begin
      if (r_state == WAIT_LAT) r_lat <= r_lat + 3'd1;
      if (w_cap) r_in_cnt <= r_in_cnt + 1'b1;
      if (w_pop) begin
        r_out_col <= w_col_end ? '0 : r_out_col + 1'b1;
        if (w_col_end) r_out_row <= (r_out_row == Y_LAST) ? '0 : r_out_row + 1'b1;
      end
    end

  // Frame status and sticky error flags; sticky flags clear only on a frame start.
  always_ff @(posedge clk)
    if (rst) begin
      r_done   <= 1'b0;
      r_active <= 1'b0;
      r_ovf    <= 1'b0;
      r_short  <= 1'b0;
      r_jerr   <= 1'b0;
    end else begin
      r_done   <= w_fin;
      r_active <= w_start || (r_active && !w_abort && !w_fin);
      r_ovf    <= !w_start && (r_ovf || w_drop);
      r_short  <= !w_start && (r_short || w_short);
      r_jerr   <= !w_start && (r_jerr || w_jerr);
    end

  assign m_valid      = r_cnt != '0;
  assign m_data       = m_valid ? r_mem[r_rp] : 8'h00;
  assign m_sof        = m_valid && r_out_row == '0 && r_out_col == '0;
  assign m_eol        = m_valid && w_col_end;
  assign m_eof        = m_valid && w_col_end && r_out_row == Y_LAST;
  assign frame_active = r_active;
  assign frame_done   = r_done;
  assign overflow     = r_ovf;
  assign short_frame  = r_short;
  assign jump_err     = r_jerr;
endmodule

// File: tb/tb_rot_pixel_framer.sv
// tb_rot_pixel_framer: scoreboard bench for rot_pixel_framer with directed frame scenarios.
module tb_rot_pixel_framer;
  localparam int W = 4;
  localparam int H = 4;
  localparam int D = 4;
  localparam int L = 1;
`ifdef FRAMER_JUMP_CHECK_EN
  localparam logic JEXP = 1'b1;
`else
  localparam logic JEXP = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1, mode_in = 1'b0, pix_jump = 1'b0, pix_done = 1'b0, m_ready = 1'b0;
  logic [7:0] pix_in = 8'h00;
  logic [7:0] m_data;
  logic       m_valid, m_sof, m_eol, m_eof, frame_active, frame_done, overflow, short_frame, jump_err;
  int         n_vec = 0, n_err = 0, cyc = 0, hs_cyc = -10;
  logic [10:0] sb[$];

  rot_pixel_framer #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D), .IN_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .mode_in(mode_in), .pix_in(pix_in), .pix_jump(pix_jump), .pix_done(pix_done),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .frame_active(frame_active), .frame_done(frame_done), .overflow(overflow),
    .short_frame(short_frame), .jump_err(jump_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Expected delivered pixels {data, sof, eol, eof}; pixels d_lo..d_hi are dropped, markers follow position.
  task automatic exp_frame(input int n_in, input int d_lo, input int d_hi);
    int p = 0;
    for (int i = 0; i < n_in; i++)
      if (i < d_lo || i > d_hi) begin
        sb.push_back({8'(i), p == 0, (p % W) == W - 1, p == W * H - 1});
        p++;
      end
  endtask

  // Monitor: every handshake is scored against the head of the queue.
  initial forever begin
    @(negedge clk);
    if (!rst && m_valid && m_ready) begin
      if (sb.size() == 0) chk("unexpected_output", {21'd0, m_data, m_sof, m_eol, m_eof}, 32'hFFFF_FFFF);
      else chk("pix", {21'd0, m_data, m_sof, m_eol, m_eof}, {21'd0, sb.pop_front()});
      hs_cyc = cyc;
    end
  end

  task automatic run_frame(input int n_rdy0, input int done_at, input int jmask);
    m_ready = (n_rdy0 == 0);
    mode_in = 1'b1;
    repeat (L + 1) begin @(posedge clk); #1; end
    for (int i = 0; i < W * H; i++) begin
      pix_in   = 8'(i);
      m_ready  = (i >= n_rdy0);
      pix_done = (i == done_at);
      pix_jump = jmask[i];
      @(posedge clk); #1;
      if (i == done_at) break;
    end
    pix_done = 1'b0;
    pix_jump = 1'b0;
    m_ready  = 1'b1;
  endtask

  task automatic wait_done(input string nm, input bit chk_hs);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    chk({nm, ".done_seen"}, 32'(k < 100), 1);
    if (k < 100 && chk_hs) chk({nm, ".done_cyc"}, cyc, hs_cyc + 1);
    chk({nm, ".active_low"}, frame_active, 0);
    @(negedge clk);
    chk({nm, ".done_pulse"}, frame_done, 0);
    chk({nm, ".sb_left"}, sb.size(), 0);
  endtask

  task automatic gap();
    @(posedge clk); #1;
    mode_in = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) begin @(posedge clk); #1; end
    chk("reset_state", {m_data, m_valid, m_sof, m_eol, m_eof, frame_active, frame_done, overflow, short_frame, jump_err}, 0);
    rst = 1'b0;
    // Clean frame.
    exp_frame(16, 99, 99);
    run_frame(0, -1, 0);
    wait_done("s1", 1'b1);
    chk("s1.overflow", overflow, 0);
    chk("s1.short", short_frame, 0);
    chk("s1.jump_err", jump_err, 0);
    gap();
    // Four stalled cycles fit exactly in the FIFO.
    exp_frame(16, 99, 99);
    run_frame(4, -1, 0);
    wait_done("s2", 1'b1);
    chk("s2.overflow", overflow, 0);
    gap();
    // Six stalled cycles drop pixels 4 and 5.
    exp_frame(16, 4, 5);
    run_frame(6, -1, 0);
    wait_done("s3", 1'b1);
    chk("s3.overflow", overflow, 1);
    gap();
    chk("s3.overflow_held", overflow, 1);
    // Early pix_done at index 9.
    exp_frame(9, 99, 99);
    run_frame(0, 9, 0);
    wait_done("s4", 1'b0);
    chk("s4.short", short_frame, 1);
    chk("s4.overflow_cleared", overflow, 0);
    gap();
    chk("s4.short_held", short_frame, 1);
    // Reset mid-frame with a full FIFO.
    m_ready = 1'b0;
    mode_in = 1'b1;
    repeat (L + 1) begin @(posedge clk); #1; end
    for (int i = 0; i < 6; i++) begin
      pix_in = 8'(i);
      @(posedge clk); #1;
    end
    chk("s5.pre_valid", m_valid, 1);
    chk("s5.pre_overflow", overflow, 1);
    chk("s5.pre_active", frame_active, 1);
    rst = 1'b1;
    mode_in = 1'b0;
    pix_in = 8'h06;
    @(posedge clk); #1;
    chk("s5.post_reset", {m_valid, frame_active, frame_done, overflow, short_frame, jump_err}, 0);
    rst = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    exp_frame(16, 99, 99);
    run_frame(0, -1, 0);
    wait_done("s5", 1'b1);
    chk("s5.overflow", overflow, 0);
    gap();
    // Row jumps at the expected indices, then a misplaced jump.
    exp_frame(16, 99, 99);
    run_frame(0, -1, (1 << 4) | (1 << 8) | (1 << 12));
    wait_done("s6a", 1'b1);
    chk("s6a.jump_err", jump_err, 0);
    gap();
    exp_frame(16, 99, 99);
    run_frame(0, -1, 1 << 5);
    wait_done("s6b", 1'b1);
    chk("s6b.jump_err", jump_err, 32'(JEXP));
    gap();
    exp_frame(16, 99, 99);
    run_frame(0, -1, (1 << 4) | (1 << 8) | (1 << 12));
    wait_done("s6c", 1'b1);
    chk("s6c.jump_err_cleared", jump_err, 0);
    gap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
